// File: rtl/fft_bitrev_reorder.sv
// fft_bitrev_reorder: ping-pong buffer returning bit-reversed FFT frames in natural order.
// Scattered writes fill one bank while sequential reads drain the other.
module fft_bitrev_reorder #(
    parameter int LGSIZE = 10,
    parameter int WIDTH  = 32
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_ce,
    input  logic             i_sync,
    input  logic [WIDTH-1:0] i_in,
    output logic [WIDTH-1:0] o_out,
    output logic             o_sync
);
    typedef enum logic [1:0] {IDLE, FILL, STREAM} state_t;
    state_t state, state_nx;
    logic [LGSIZE-1:0] pos, pos_nx, pos_rev;
    logic bank, bank_nx, start, wr_en, rd_en;
    logic [LGSIZE:0] wr_addr;
    logic [WIDTH-1:0] mem [0:(2<<LGSIZE)-1];

    for (genvar b = 0; b < LGSIZE; b++) begin : g_rev
        assign pos_rev[b] = pos[LGSIZE-1-b];
    end

    always_ff @(posedge i_clk)
        if (i_reset) begin
            state <= IDLE;
            pos   <= '0;
            bank  <= 1'b0;
        end else begin
            state <= state_nx;
            pos   <= pos_nx;
            bank  <= bank_nx;
        end

    // A sync anywhere but frame start (re)starts filling bank 0 from scratch.
    always_comb begin
        state_nx = state;
        pos_nx   = pos;
        bank_nx  = bank;
        wr_en    = 1'b0;
        rd_en    = 1'b0;
        wr_addr  = {bank, pos_rev};
        start    = i_sync && (state == IDLE || pos != '0);
        if (i_ce) begin
            if (start) begin
                state_nx = FILL;
                pos_nx   = LGSIZE'(1);
                bank_nx  = 1'b0;
                wr_en    = 1'b1;
                wr_addr  = '0;
            end else if (state != IDLE) begin
                wr_en  = 1'b1;
                rd_en  = state == STREAM;
                pos_nx = pos + 1'b1;
                if (&pos) begin
                    bank_nx  = ~bank;
                    state_nx = STREAM;
                end
            end
        end
    end

    always_ff @(posedge i_clk)
        if (wr_en) mem[wr_addr] <= i_in;

    always_ff @(posedge i_clk)
        if (i_reset) begin
            o_out  <= '0;
            o_sync <= 1'b0;
        end else if (i_ce) begin
            o_sync <= rd_en && pos == '0;
            if (rd_en) o_out <= mem[{~bank, pos}];
        end
endmodule

// File: tb/tb_fft_bitrev_reorder.sv
// tb_fft_bitrev_reorder: directed checks of the bit-reverse reorder buffer with N=8.
module tb_fft_bitrev_reorder;
    localparam int LG = 3;
    localparam int W  = 16;
    logic i_clk = 1'b0, i_reset = 1'b1, i_ce = 1'b0, i_sync = 1'b0;
    logic [W-1:0] i_in = '0;
    logic [W-1:0] o_out;
    logic o_sync;
    int n_chk = 0, n_fail = 0;
    int nat [8] = '{0, 4, 2, 6, 1, 5, 3, 7};

    always #5 i_clk = ~i_clk;

    fft_bitrev_reorder #(.LGSIZE(LG), .WIDTH(W)) dut (
        .i_clk(i_clk), .i_reset(i_reset), .i_ce(i_ce), .i_sync(i_sync),
        .i_in(i_in), .o_out(o_out), .o_sync(o_sync)
    );

    task automatic tick(input logic ce, input logic sy, input logic [W-1:0] d);
        i_ce = ce;
        i_sync = sy;
        i_in = d;
        @(posedge i_clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic chk_out(input string tag, input int ev, input logic es);
        chk({tag, "_out"}, o_out, W'(ev));
        chk({tag, "_sync"}, W'(o_sync), W'(es));
    endtask

    task automatic do_reset();
        i_reset = 1'b1;
        tick(1'b1, 1'b0, '0);
        tick(1'b0, 1'b0, '0);
        i_reset = 1'b0;
    endtask

    // Frames 0..7 then 10..17, then a drain; gap disabled clocks (with a
    // spurious sync) after each enabled one must leave the outputs untouched.
    task automatic frames(input int gap);
        int e;
        logic s;
        for (int j = 0; j < 24; j++) begin
            tick(1'b1, j == 0 || j == 8, W'(j < 8 ? j : (j < 16 ? j + 2 : 0)));
            if (j < 8) e = 0;
            else if (j < 16) e = nat[j-8];
            else e = 10 + nat[j-16];
            s = j == 8 || j == 16;
            chk_out("frames", e, s);
            for (int g = 0; g < gap; g++) begin
                tick(1'b0, 1'b1, 16'hdead);
                chk_out("hold", e, s);
            end
        end
    endtask

    initial begin
        tick(1'b0, 1'b0, '0);
        tick(1'b0, 1'b0, '0);
        chk_out("reset", 0, 1'b0);
        i_reset = 1'b0;

        frames(0);

        do_reset();
        frames(2);

        do_reset();
        for (int j = 0; j < 20; j++) begin
            tick(1'b1, 1'b0, W'(100 + j));
            chk_out("nosync", 0, 1'b0);
        end
        frames(0);

        do_reset();
        for (int j = 0; j < 21; j++) begin
            tick(1'b1, j == 0 || j == 5, W'(j < 5 ? 50 + j : (j < 13 ? 55 + j : 0)));
            if (j < 13) chk_out("resync_wait", 0, 1'b0);
            else chk_out("resync", 60 + nat[j-13], j == 13);
        end

        do_reset();
        for (int j = 0; j < 10; j++) begin
            tick(1'b1, j == 0, W'(j));
            if (j >= 8) chk_out("pre_rst", nat[j-8], j == 8);
        end
        i_reset = 1'b1;
        tick(1'b1, 1'b1, W'(99));
        chk_out("rst_mid", 0, 1'b0);
        i_reset = 1'b0;
        for (int j = 0; j < 12; j++) begin
            tick(1'b1, 1'b0, W'(200 + j));
            chk_out("post_rst_idle", 0, 1'b0);
        end
        for (int j = 0; j < 16; j++) begin
            tick(1'b1, j == 0, W'(j < 8 ? 70 + j : 0));
            if (j < 8) chk_out("post_rst_fill", 0, 1'b0);
            else chk_out("post_rst_frame", 70 + nat[j-8], j == 8);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/fft_bitrev_reorder.md
# fft_bitrev_reorder

Frame reorder buffer that sits downstream of the pipelined FFT output (`o_result`/`o_sync`). The FFT delivers frames in bit-reversed index order, and this block returns each frame in natural order. It is a ping-pong buffer of two banks of 2^LGSIZE words: one bank fills while the other drains. Output cadence follows the same `i_ce` clock-enable scheme as the FFT, one word in and one word out per enabled clock.

## Interface
- `LGSIZE`, default 10: log2 of the frame length N.
- `WIDTH`, default 32: sample width, packed complex (real in high half).
- `i_clk`, input, 1: clock; all logic is synchronous to its rising edge.
- `i_reset`, input, 1: synchronous reset, active-high; clock is `i_clk`.
- `i_ce`, input, 1: clock enable. Each enabled edge accepts one word and produces one word.
- `i_sync`, input, 1: marks the first (bit-reversed position 0) sample of a frame; qualified by `i_ce`.
- `i_in`, input, WIDTH: input sample, bit-reversed order.
- `o_out`, output, WIDTH: output sample, natural order; registered.
- `o_sync`, output, 1: high while `o_out` holds natural index 0 of a complete frame; registered.

## Operation
- **Storage:** 2·N words. Bank select is `bank` (1 bit). Position counter is `pos[LGSIZE-1:0]`.
- **State machine** (regs `locked`, `full`), updated only on `i_ce`:
  - **IDLE** (`locked`=0): inputs are ignored and nothing is written. On `i_ce && i_sync`: write `i_in` to {bank=0, addr 0}, set `pos`=1, go to FILL.
  - **FILL** (`locked`=1, `full`=0): write `i_in` to {bank, rev(pos)} and increment `pos`. When `pos` wraps from N−1 to 0, toggle `bank` and go to STREAM.
  - **STREAM** (`locked`=1, `full`=1): on the same edge, write {bank, rev(pos)}, read {~bank, pos} into `o_out`, and increment `pos`. On wrap, toggle `bank`.
- `rev()` reverses the LGSIZE bits. Writes are scattered; reads are sequential.
- **`o_sync`:** set on the STREAM edge that reads addr 0 of the drain bank. Cleared on the next `i_ce` edge. It holds its value between enables.
- **`i_sync` handling:**
  - `i_sync` with `pos`==0 while locked is expected and causes no action.
  - `i_sync` with `pos`≠0 is a resync. Treat it as IDLE→FILL: write the sample to bank 0 addr 0, set `pos`=1, clear `full`, clear `o_sync`.
  - After a resync, `o_out` holds its last value until STREAM is reached again.
- Frames without `i_sync` while locked are accepted; the counter free-runs.
- In FILL and IDLE, `o_out` and `o_sync` do not change except as stated above.
- No arithmetic is performed. Data passes through bit-exact.

## Timing
- **Reset values:** `o_out`=0, `o_sync`=0, `pos`=0, `bank`=0, `locked`=0, `full`=0. Memory contents are not reset.
- A reset mid-frame abandons both banks. The first output after reset comes only after a new `i_sync` plus N enabled cycles.
- **Latency:** if frame F's first sample is accepted on enabled edge k, natural index n of frame F appears on `o_out` at enabled edge k+N+n. Latency is counted in `i_ce` edges only; clocks without `i_ce` change nothing.
- **Throughput:** one word per `i_ce`, sustained indefinitely, with no stalls or backpressure.
- **Bank wrap:** the write at `pos`=N−1 and the bank toggle happen on the same edge. The next edge reads addr 0 of the just-filled bank.
- **Read/write collisions:** reads and writes always target opposite banks, so there is no read-during-write hazard. A registered-read inferred RAM (one write port, one read port) is sufficient.
- **Reset vs. sync:** if `i_reset` and `i_sync` are asserted together, reset wins.

## Test plan
All scenarios use LGSIZE=3 (N=8).
- **Basic reorder:** `i_ce`=1 continuously. `i_sync` at the first edge. Inputs 0..7, then 10..17 with `i_sync` again.
  - 9th edge onward: `o_out` = 0,4,2,6,1,5,3,7 (natural order of the first frame).
  - `o_sync`=1 only with the first of these.
  - Next frame out: 10,14,12,16,11,15,13,17.
- **Sparse enable:** same stimulus with `i_ce` toggling 1,0,0,1. Output values and order are identical to the basic case. `o_out`/`o_sync` change only on enabled edges.
- **No sync:** 20 enabled inputs with `i_sync`=0. `o_out` stays 0 and `o_sync` stays 0 throughout. Then assert `i_sync` and run 16 samples; behaviour matches the basic case.
- **Mid-frame resync:** `i_sync` at input 0, then `i_sync` again at input 5.
  - `o_sync` stays 0 until 8 enabled edges after the second `i_sync`.
  - The following output frame is the natural-order version of the 8 samples starting at the second `i_sync`.
- **Reset mid-operation:** assert `i_reset` during the 3rd output of STREAM.
  - Next edge: `o_out`=0, `o_sync`=0.
  - No output until a new `i_sync` plus 8 enabled edges.
  - After that, output order is correct with no stale bank data emitted.
